// File: rtl/beagleg_pkg.sv
// Shared constants and types for the SPI record path: command byte,
// status byte bit positions and the framer state encoding.
package beagleg_pkg;

    localparam logic [7:0] CMD_RECORD_DEFAULT = 8'hA5;

    localparam int STATUS_BUSY_BIT    = 7;
    localparam int STATUS_READY_BIT   = 6;
    localparam int STATUS_AVAIL_BIT   = 5;
    localparam int STATUS_CKSUM_BIT   = 4;
    localparam int STATUS_OVERRUN_BIT = 3;
    localparam int ACCEPT_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECKSUM,
        ST_DRAIN
    } framer_state_t;

endpackage

// File: rtl/record_buffer.sv
// Small byte register file holding one record payload; write port plus
// combinational read so the drain path can present a byte the same cycle.
module record_buffer #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [7:0]       rdata
);

    logic [7:0] entry_array [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [7:0] entry_reg;

            always_ff @(posedge clk) begin
                if (we && (widx == IDX_W'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entry_array[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entry_array[ridx];

endmodule

// File: rtl/spi_record_framer.sv
// Frames the SPI byte stream into checksummed records and forwards only
// verified records to the fifo; returns a status byte on every SPI word.
module spi_record_framer
    import beagleg_pkg::*;
#(
    parameter int         RECORD_SIZE_BYTES = 16,
    parameter logic [7:0] CMD_RECORD        = CMD_RECORD_DEFAULT,
    parameter int         COUNTER_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_select_n,
    input  logic                     word_ready,
    input  logic [7:0]               data_word_received,
    output logic [7:0]               data_word_to_send,
    input  logic                     fifo_in_ready,
    output logic [7:0]               fifo_in_byte,
    output logic                     fifo_in_clk,
    input  logic                     fifo_out_available,
    output logic                     frame_accepted,
    output logic [COUNTER_WIDTH-1:0] err_checksum_count,
    output logic [COUNTER_WIDTH-1:0] err_overrun_count
);

    localparam int IDX_W = (RECORD_SIZE_BYTES > 1) ? $clog2(RECORD_SIZE_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_SIZE_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    framer_state_t state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] rd_reg, rd_next;
    logic [7:0] sum_reg, sum_next;
    logic [COUNTER_WIDTH-1:0] cksum_cnt_reg, cksum_cnt_next;
    logic [COUNTER_WIDTH-1:0] overrun_cnt_reg, overrun_cnt_next;
    logic cksum_err_reg, cksum_err_next;
    logic overrun_reg, overrun_next;
    logic [ACCEPT_CNT_W-1:0] accepted_reg, accepted_next;
    logic frame_accepted_reg, frame_accepted_next;
    logic [7:0] status_reg, status_next;

    logic       buf_we;
    logic [7:0] buf_rdata;
    logic [7:0] byte_sum;
    logic       draining;

    assign byte_sum = sum_reg + data_word_received;
    assign draining = (state_reg == ST_DRAIN);

    record_buffer #(
        .DEPTH (RECORD_SIZE_BYTES),
        .IDX_W (IDX_W)
    ) u_record_buffer (
        .clk   (clk),
        .we    (buf_we),
        .widx  (idx_reg),
        .wdata (data_word_received),
        .ridx  (rd_reg),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_next          = state_reg;
        idx_next            = idx_reg;
        rd_next             = rd_reg;
        sum_next            = sum_reg;
        cksum_cnt_next      = cksum_cnt_reg;
        overrun_cnt_next    = overrun_cnt_reg;
        cksum_err_next      = cksum_err_reg;
        overrun_next        = overrun_reg;
        accepted_next       = accepted_reg;
        frame_accepted_next = 1'b0;
        buf_we              = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (word_ready && (data_word_received == CMD_RECORD)) begin
                    state_next = ST_PAYLOAD;
                    idx_next   = '0;
                    sum_next   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (word_ready) begin
                    buf_we   = 1'b1;
                    sum_next = byte_sum;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_CHECKSUM;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            ST_CHECKSUM: begin
                if (word_ready) begin
                    if (byte_sum == 8'h00) begin
                        state_next     = ST_DRAIN;
                        rd_next        = '0;
                        cksum_err_next = 1'b0;
                    end else begin
                        state_next     = ST_IDLE;
                        cksum_err_next = 1'b1;
                        if (cksum_cnt_reg != CNT_MAX) begin
                            cksum_cnt_next = cksum_cnt_reg + COUNTER_WIDTH'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                // Incoming bytes are dropped while draining; a new record
                // command here means the host ignored the busy flag.
                if (word_ready && (data_word_received == CMD_RECORD)) begin
                    overrun_next = 1'b1;
                    if (overrun_cnt_reg != CNT_MAX) begin
                        overrun_cnt_next = overrun_cnt_reg + COUNTER_WIDTH'(1);
                    end
                end
                if (fifo_in_ready) begin
                    if (rd_reg == LAST_IDX) begin
                        state_next          = ST_IDLE;
                        frame_accepted_next = 1'b1;
                        accepted_next       = accepted_reg + ACCEPT_CNT_W'(1);
                    end else begin
                        rd_next = rd_reg + IDX_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Chip-select release discards any partially received record.
        if (spi_select_n && ((state_next == ST_PAYLOAD) || (state_next == ST_CHECKSUM))) begin
            state_next = ST_IDLE;
        end

        status_next                     = '0;
        status_next[STATUS_BUSY_BIT]    = draining;
        status_next[STATUS_READY_BIT]   = fifo_in_ready;
        status_next[STATUS_AVAIL_BIT]   = fifo_out_available;
        status_next[STATUS_CKSUM_BIT]   = cksum_err_reg;
        status_next[STATUS_OVERRUN_BIT] = overrun_reg;
        status_next[ACCEPT_CNT_W-1:0]   = accepted_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= ST_IDLE;
            idx_reg            <= '0;
            rd_reg             <= '0;
            sum_reg            <= '0;
            cksum_cnt_reg      <= '0;
            overrun_cnt_reg    <= '0;
            cksum_err_reg      <= 1'b0;
            overrun_reg        <= 1'b0;
            accepted_reg       <= '0;
            frame_accepted_reg <= 1'b0;
            status_reg         <= '0;
        end else begin
            state_reg          <= state_next;
            idx_reg            <= idx_next;
            rd_reg             <= rd_next;
            sum_reg            <= sum_next;
            cksum_cnt_reg      <= cksum_cnt_next;
            overrun_cnt_reg    <= overrun_cnt_next;
            cksum_err_reg      <= cksum_err_next;
            overrun_reg        <= overrun_next;
            accepted_reg       <= accepted_next;
            frame_accepted_reg <= frame_accepted_next;
            status_reg         <= status_next;
        end
    end

    assign fifo_in_clk        = draining;
    assign fifo_in_byte       = draining ? buf_rdata : 8'h00;
    assign frame_accepted     = frame_accepted_reg;
    assign data_word_to_send  = status_reg;
    assign err_checksum_count = cksum_cnt_reg;
    assign err_overrun_count  = overrun_cnt_reg;

endmodule

// File: tb/tb_spi_record_framer.sv
// Directed bench for spi_record_framer: good/bad records, backpressure,
// chip-select abort, overrun and reset during drain.
module tb_spi_record_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_select_n = 1'b1;
    logic       word_ready = 1'b0;
    logic [7:0] data_word_received = 8'h00;
    logic       fifo_in_ready = 1'b1;
    logic       fifo_out_available = 1'b0;
    logic [7:0] data_word_to_send;
    logic [7:0] fifo_in_byte;
    logic       fifo_in_clk;
    logic       frame_accepted;
    logic [7:0] err_checksum_count;
    logic [7:0] err_overrun_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] wr_q [$];
    int wr_cyc [$];
    int acc_count = 0;
    int acc_cyc = 0;

    spi_record_framer dut (
        .clk                (clk),
        .rst                (rst),
        .spi_select_n       (spi_select_n),
        .word_ready         (word_ready),
        .data_word_received (data_word_received),
        .data_word_to_send  (data_word_to_send),
        .fifo_in_ready      (fifo_in_ready),
        .fifo_in_byte       (fifo_in_byte),
        .fifo_in_clk        (fifo_in_clk),
        .fifo_out_available (fifo_out_available),
        .frame_accepted     (frame_accepted),
        .err_checksum_count (err_checksum_count),
        .err_overrun_count  (err_overrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Inputs change 1ns after posedge, so the negedge sees settled values.
    always @(negedge clk) begin
        if (fifo_in_clk && fifo_in_ready) begin
            wr_q.push_back(fifo_in_byte);
            wr_cyc.push_back(cyc);
            $display("fifo write byte=%02h cycle=%0d", fifo_in_byte, cyc);
        end
        if (frame_accepted) begin
            acc_count++;
            acc_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        data_word_received = b;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
    endtask

    // Returns the cycle index at which the checksum byte was taken.
    task automatic send_frame(input logic [7:0] cks, output int cks_cyc);
        send_byte(8'hA5);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(cks);
        cks_cyc = cyc;
        $display("frame sent checksum=%02h at cycle %0d", cks, cks_cyc);
    endtask

    task automatic wait_frame(input int prev, input string name);
        int n = 0;
        while (acc_count == prev && n < 300) begin
            tick(1);
            n++;
        end
        checks++;
        if (acc_count == prev) begin
            errors++;
            $display("FAIL %s: frame_accepted never seen (count %0d, required %0d)", name, acc_count, prev + 1);
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (fifo_in_clk !== 1'b0) begin errors++; $display("FAIL reset_fifo_clk: got %b want 0", fifo_in_clk); end
        checks++;
        if (data_word_to_send !== 8'h00) begin errors++; $display("FAIL reset_status: got %02h want 00", data_word_to_send); end
        checks++;
        if (err_checksum_count !== 8'h00 || err_overrun_count !== 8'h00) begin
            errors++; $display("FAIL reset_counters: got %02h/%02h want 00/00", err_checksum_count, err_overrun_count);
        end
        checks++;
        if (frame_accepted !== 1'b0 || fifo_in_byte !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got fa=%b byte=%02h want 0/00", frame_accepted, fifo_in_byte);
        end
        rst = 1'b1;
        tick(3);
        checks++;
        if (data_word_to_send !== 8'h40) begin errors++; $display("FAIL idle_status: got %02h want 40", data_word_to_send); end
    endtask

    task automatic test_good_record();
        int base, prev, c;
        base = wr_q.size();
        prev = acc_count;
        spi_select_n = 1'b0;
        send_frame(8'h78, c);
        wait_frame(prev, "good_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL good_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL good_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
            checks++;
            if (wr_cyc[base] != c || wr_cyc[base+15] != c + 15) begin
                errors++; $display("FAIL good_timing: first/last at %0d/%0d want %0d/%0d", wr_cyc[base], wr_cyc[base+15], c, c + 15);
            end
        end
        checks++;
        if (acc_cyc != c + 16 || acc_count != prev + 1) begin
            errors++; $display("FAIL good_accept: cycle %0d count %0d want cycle %0d count %0d", acc_cyc, acc_count, c + 16, prev + 1);
        end
        checks++;
        if (data_word_to_send !== 8'h41) begin errors++; $display("FAIL good_status: got %02h want 41", data_word_to_send); end
    endtask

    task automatic test_bad_checksum();
        int base, prev, c;
        base = wr_q.size();
        prev = acc_count;
        send_frame(8'h79, c);
        tick(30);
        checks++;
        if (wr_q.size() != base || acc_count != prev) begin
            errors++; $display("FAIL bad_writes: got %0d writes %0d accepts want 0/0", wr_q.size() - base, acc_count - prev);
        end
        checks++;
        if (err_checksum_count !== 8'd1) begin errors++; $display("FAIL bad_count: got %0d want 1", err_checksum_count); end
        checks++;
        if (data_word_to_send !== 8'h51) begin errors++; $display("FAIL bad_status: got %02h want 51", data_word_to_send); end
        send_frame(8'h78, c);
        wait_frame(prev, "after_bad_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL after_bad_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL after_bad_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (data_word_to_send !== 8'h42) begin errors++; $display("FAIL after_bad_status: got %02h want 42", data_word_to_send); end
    endtask

    task automatic test_backpressure();
        int base, prev, c, n;
        base = wr_q.size();
        prev = acc_count;
        send_frame(8'h78, c);
        n = 0;
        while (wr_q.size() < base + 3 && n < 100) begin
            tick(1);
            n++;
        end
        fifo_in_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (fifo_in_clk !== 1'b1 || fifo_in_byte !== 8'h04) begin
                errors++; $display("FAIL bp_hold: got clk=%b byte=%02h want 1/04", fifo_in_clk, fifo_in_byte);
            end
        end
        @(posedge clk);
        #1;
        fifo_in_ready = 1'b1;
        wait_frame(prev, "bp_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL bp_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL bp_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (data_word_to_send !== 8'h43) begin errors++; $display("FAIL bp_status: got %02h want 43", data_word_to_send); end
    endtask

    task automatic test_cs_abort();
        int base, prev, c;
        base = wr_q.size();
        prev = acc_count;
        send_byte(8'hA5);
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        spi_select_n = 1'b1;
        tick(5);
        checks++;
        if (wr_q.size() != base || fifo_in_clk !== 1'b0 || data_word_to_send[7] !== 1'b0) begin
            errors++; $display("FAIL abort_idle: writes %0d clk=%b busy=%b want 0/0/0", wr_q.size() - base, fifo_in_clk, data_word_to_send[7]);
        end
        spi_select_n = 1'b0;
        tick(2);
        send_frame(8'h78, c);
        wait_frame(prev, "abort_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL abort_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL abort_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (data_word_to_send[2:0] !== 3'd4) begin errors++; $display("FAIL abort_accepted: got %0d want 4", data_word_to_send[2:0]); end
    endtask

    task automatic test_overrun();
        int base, prev, c;
        base = wr_q.size();
        prev = acc_count;
        fifo_in_ready = 1'b0;
        send_frame(8'h78, c);
        tick(2);
        send_byte(8'hA5);
        tick(3);
        checks++;
        if (data_word_to_send !== 8'h8C) begin errors++; $display("FAIL ovr_status: got %02h want 8c", data_word_to_send); end
        checks++;
        if (err_overrun_count !== 8'd1) begin errors++; $display("FAIL ovr_count: got %0d want 1", err_overrun_count); end
        checks++;
        if (wr_q.size() != base || fifo_in_clk !== 1'b1 || fifo_in_byte !== 8'h01) begin
            errors++; $display("FAIL ovr_hold: writes %0d clk=%b byte=%02h want 0/1/01", wr_q.size() - base, fifo_in_clk, fifo_in_byte);
        end
        fifo_in_ready = 1'b1;
        wait_frame(prev, "ovr_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL ovr_drain_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL ovr_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (data_word_to_send !== 8'h4D) begin errors++; $display("FAIL ovr_after_status: got %02h want 4d", data_word_to_send); end
        spi_select_n = 1'b1;
        tick(2);
        spi_select_n = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int base, prev, c, n;
        base = wr_q.size();
        send_frame(8'h78, c);
        n = 0;
        while (wr_q.size() < base + 5 && n < 100) begin
            tick(1);
            n++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fifo_in_clk !== 1'b0 || frame_accepted !== 1'b0) begin
            errors++; $display("FAIL rst_drain_clk: got clk=%b fa=%b want 0/0", fifo_in_clk, frame_accepted);
        end
        checks++;
        if (data_word_to_send !== 8'h00 || err_checksum_count !== 8'h00 || err_overrun_count !== 8'h00) begin
            errors++; $display("FAIL rst_drain_state: got status=%02h ck=%0d ov=%0d want 00/0/0", data_word_to_send, err_checksum_count, err_overrun_count);
        end
        tick(3);
        checks++;
        if (wr_q.size() != base + 5) begin errors++; $display("FAIL rst_drain_writes: got %0d want 5", wr_q.size() - base); end
        rst = 1'b1;
        fifo_out_available = 1'b1;
        tick(2);
        base = wr_q.size();
        prev = acc_count;
        send_frame(8'h78, c);
        wait_frame(prev, "rst_frame");
        tick(3);
        checks++;
        if (wr_q.size() != base + 16) begin
            errors++; $display("FAIL rst_frame_count: got %0d writes want 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base+i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL rst_frame_byte%0d: got %02h want %02h", i, wr_q[base+i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (data_word_to_send !== 8'h61) begin errors++; $display("FAIL rst_frame_status: got %02h want 61", data_word_to_send); end
    endtask

    initial begin
        test_reset();
        test_good_record();
        test_bad_checksum();
        test_backpressure();
        test_cs_abort();
        test_overrun();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_record_framer.md
Name: spi_record_framer

Overview:
- Sits between spi_secondary and fifo.
- Parses the byte stream received over SPI into framed motion records: command byte, RECORD_SIZE_BYTES payload, 8-bit checksum.
- Buffers each record internally and pushes it byte-by-byte into the fifo only after the checksum verifies, so the fifo never holds partial or corrupt records.
- Supplies a status byte back to the SPI host on every transfer.

Parameters:
- RECORD_SIZE_BYTES, 16, payload bytes per record; must match fifo RECORD_SIZE_BYTES.
- CMD_RECORD, 8'hA5, command byte that opens a record frame; any other command byte is a status poll.
- COUNTER_WIDTH, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- spi_select_n  in  1  chip select from SPI pins, already synchronized to clk; low = frame active.
- word_ready  in  1  one-cycle strobe from spi_secondary: a new byte is valid.
- data_word_received  in  8  byte received; valid while word_ready=1.
- data_word_to_send  out  8  status byte for the next SPI word.
- fifo_in_ready  in  1  fifo can accept a byte this cycle.
- fifo_in_byte  out  8  byte to fifo.
- fifo_in_clk  out  1  write strobe; a byte transfers on a cycle where fifo_in_clk & fifo_in_ready.
- fifo_out_available  in  1  fifo holds at least one record; reported in status only.
- frame_accepted  out  1  one-cycle pulse per record fully written to the fifo.
- err_checksum_count  out  COUNTER_WIDTH  saturating count of checksum failures.
- err_overrun_count  out  COUNTER_WIDTH  saturating count of record commands received while busy.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, all counters 0, sticky flags 0, accepted counter 0.
- States:
  - IDLE: word_ready with byte==CMD_RECORD -> PAYLOAD, idx=0, sum=0. Any other byte is ignored and leaves state IDLE.
  - PAYLOAD: on each word_ready, store byte at buf[idx], sum+=byte (mod 256), idx++. When idx reaches RECORD_SIZE_BYTES-1 and that byte is stored -> CHECKSUM.
  - CHECKSUM: on word_ready:
    - If (sum+byte) mod 256 == 0 -> DRAIN, rd=0, clear cksum_err flag.
    - Else -> IDLE, err_checksum_count++ (saturating), set sticky cksum_err.
  - DRAIN: fifo_in_clk=1 and fifo_in_byte=buf[rd] every cycle, starting the cycle after entering DRAIN.
    - rd advances only on fifo_in_clk & fifo_in_ready; the byte is held stable while not ready. Bytes go out in receive order, byte 0 first.
    - After byte RECORD_SIZE_BYTES-1 is accepted: fifo_in_clk=0 in the following cycle, frame_accepted pulses in that same cycle, the 3-bit accepted counter increments (wrapping), and state returns to IDLE.
- Multiple records per chip-select assertion are allowed; after each CHECKSUM or DRAIN completion the parser expects a new command byte.
- Chip-select abort: the next state is computed with word_ready first. If spi_select_n=1 and the resulting state is PAYLOAD or CHECKSUM, force IDLE; the partial record is discarded and nothing is written to the fifo. DRAIN is never aborted by chip-select.
- During DRAIN every received byte is discarded.
  - If a discarded byte equals CMD_RECORD: err_overrun_count++ (saturating) and set sticky overrun flag.
  - Host contract: do not send a record while busy=1. After a violation, resync is guaranteed only by deasserting chip-select.
- Status byte (data_word_to_send), registered and updated every clk cycle:
  - bit7 busy (state==DRAIN)
  - bit6 fifo_in_ready
  - bit5 fifo_out_available
  - bit4 cksum_err sticky
  - bit3 overrun sticky
  - bits2:0 accepted counter
  - Sticky flags clear only on reset, except that cksum_err also clears on a valid checksum.
- Latency: checksum byte accepted at cycle N -> first fifo_in_clk at N+1. Best case last write at N+RECORD_SIZE_BYTES, frame_accepted at N+RECORD_SIZE_BYTES+1.
- word_ready while PAYLOAD with spi_select_n rising in the same cycle: the byte is stored, then the frame aborts.

Decomposition:
- Package beagleg_pkg: CMD_RECORD default, status bit position constants, framer state enum (IDLE, PAYLOAD, CHECKSUM, DRAIN).
- One sub-module, record_buffer: RECORD_SIZE_BYTES x 8 register file with write port (we, widx, wdata) and combinational read (ridx -> rdata).
- The framer owns the FSM, indices, checksum accumulator, counters and status.

Test Plan:
- Good record: select, send A5, 0x01..0x10, 0x78 (sum 0x88 + 0x78 = 0) with fifo_in_ready=1 -> 16 writes 0x01..0x10 in order on consecutive cycles, one frame_accepted, status bits2:0=1, bit4=0.
- Bad checksum: same frame ending 0x79 -> zero fifo writes, err_checksum_count=1, status bit4=1. A following good frame -> bit4=0 and writes occur.
- Backpressure: fifo_in_ready low for 5 cycles after the 3rd write -> fifo_in_byte held at 0x04 with fifo_in_clk=1, then 0x04..0x10 exactly once each, 16 total.
- Chip-select abort: A5 + 7 payload bytes, then deassert -> no writes, state IDLE. Reselect with a good frame -> 16 correct writes.
- Overrun: fifo_in_ready=0, complete a good frame, send A5 -> status bit7=1, err_overrun_count=1, bit3=1. Release ready -> first record drains intact.
- Reset mid-DRAIN after 5 writes: rst=0 -> fifo_in_clk=0, all counters and status 0 immediately. After release, a good frame -> 16 writes.
